// File: rtl/gray_counter_if.sv
// Control/status bundle for gray_counter: the controller drives the master
// side (clr/load/en/up) and observes the binary count, the Gray count and wrap.
interface gray_counter_if #(
  parameter int W = 4
);
  logic         clr;
  logic         load;
  logic [W-1:0] load_val;
  logic         en;
  logic         up;
  logic [W-1:0] cnt_bin;
  logic [W-1:0] cnt_gray;
  logic         wrap;

  modport master (
    output clr, load, load_val, en, up,
    input  cnt_bin, cnt_gray, wrap
  );

  modport slave (
    input  clr, load, load_val, en, up,
    output cnt_bin, cnt_gray, wrap
  );
endinterface

// File: rtl/gray_counter.sv
// Registered up/down binary counter with a flop-sourced Gray copy and wrap pulse.
// Define GRAY_CNT_SAT_EN to saturate at the boundaries instead of wrapping.
module gray_counter #(
  parameter int W = 4
) (
  input logic          clk,
  input logic          rst_n,
  gray_counter_if.slave bus
);

  localparam logic [W-1:0] ZERO_C = {W{1'b0}};
  localparam logic [W-1:0] ONE_C  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] MAX_C  = {W{1'b1}};

  function automatic logic [W-1:0] bin2gray(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [W-1:0] bin_r;
  logic [W-1:0] gray_r;
  logic         wrap_r;
  logic [W-1:0] next_bin_s;
  logic         next_wrap_s;

  // Next-state selection: clr, then load, then an enabled step, else hold.
  always_comb begin
    next_bin_s  = bin_r;
    next_wrap_s = 1'b0;
    if (bus.clr) begin
      next_bin_s = ZERO_C;
    end else if (bus.load) begin
      next_bin_s = bus.load_val;
    end else if (bus.en) begin
      if (bus.up) begin
        if (bin_r == MAX_C) begin
          next_wrap_s = 1'b1;
`ifdef GRAY_CNT_SAT_EN
          next_bin_s  = MAX_C;
`else
          next_bin_s  = ZERO_C;
`endif
        end else begin
          next_bin_s = bin_r + ONE_C;
        end
      end else begin
        if (bin_r == ZERO_C) begin
          next_wrap_s = 1'b1;
`ifdef GRAY_CNT_SAT_EN
          next_bin_s  = ZERO_C;
`else
          next_bin_s  = MAX_C;
`endif
        end else begin
          next_bin_s = bin_r - ONE_C;
        end
      end
    end else begin
      next_bin_s  = bin_r;
      next_wrap_s = 1'b0;
    end
  end

  // Gray is encoded from the next binary value so both copies update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_r  <= ZERO_C;
      gray_r <= ZERO_C;
      wrap_r <= 1'b0;
    end else begin
      bin_r  <= next_bin_s;
      gray_r <= bin2gray(next_bin_s);
      wrap_r <= next_wrap_s;
    end
  end

  assign bus.cnt_bin  = bin_r;
  assign bus.cnt_gray = gray_r;
  assign bus.wrap     = wrap_r;

endmodule

// File: tb/tb_gray_counter.sv
// Scoreboard bench for gray_counter: the driver queues expected results, a
// monitor pops them one cycle later and also checks the Gray invariants.
module tb_gray_counter;
  localparam int W = 4;

  typedef struct {
    logic [W-1:0] bin;
    logic [W-1:0] gray;
    logic         wrap;
    bit           step;
    string        name;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];
  logic [W-1:0] prev_gray;
  logic [W-1:0] mdl_bin;
  logic [W-1:0] gray_tab [16];

  gray_counter_if #(.W(W)) bus ();

  gray_counter #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d (%b), expected %0d (%b) at %0t", nm, act, act, req, req, $time);
    end
  endtask

  task automatic drive(input logic c, input logic l, input logic e, input logic u,
                       input logic [W-1:0] lv, input logic [W-1:0] eb,
                       input logic [W-1:0] eg, input logic ew, input bit stp,
                       input string nm);
    exp_t x;
    @(negedge clk);
    bus.clr = c; bus.load = l; bus.en = e; bus.up = u; bus.load_val = lv;
    x.bin = eb; x.gray = eg; x.wrap = ew; x.step = stp; x.name = nm;
    sb.push_back(x);
  endtask

  task automatic idle_inputs();
    bus.clr = 1'b0; bus.load = 1'b0; bus.en = 1'b0; bus.up = 1'b0;
    bus.load_val = {W{1'b0}};
  endtask

  // Assert reset between edges just after the last queued result appears.
  task automatic async_reset(input string nm);
    @(posedge clk);
    #2;
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk({nm, "_bin"}, bus.cnt_bin, 4'd0);
    chk({nm, "_gray"}, bus.cnt_gray, 4'd0);
    chk({nm, "_wrap"}, {3'd0, bus.wrap}, 4'd0);
    @(posedge clk);
    #1;
    chk({nm, "_hold_bin"}, bus.cnt_bin, 4'd0);
    chk({nm, "_hold_wrap"}, {3'd0, bus.wrap}, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: invariant every cycle, scoreboard entry whenever one is pending.
  initial begin
    exp_t x;
    prev_gray = {W{1'b0}};
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        chk("gray_invariant", bus.cnt_gray, bus.cnt_bin ^ (bus.cnt_bin >> 1));
        if (sb.size() > 0) begin
          x = sb.pop_front();
          chk({x.name, "_bin"}, bus.cnt_bin, x.bin);
          chk({x.name, "_gray"}, bus.cnt_gray, x.gray);
          chk({x.name, "_wrap"}, {3'd0, bus.wrap}, {3'd0, x.wrap});
          if (x.step)
            chk({x.name, "_one_bit_toggle"}, 4'($countones(bus.cnt_gray ^ prev_gray)), 4'd1);
        end
      end
      prev_gray = bus.cnt_gray;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] b;
    logic c, l, e, u, w, stp;
    logic [W-1:0] lv;
    n_checks = 0;
    n_fail   = 0;
    gray_tab = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("reset_bin", bus.cnt_bin, 4'd0);
    chk("reset_gray", bus.cnt_gray, 4'd0);
    chk("reset_wrap", {3'd0, bus.wrap}, 4'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

`ifndef GRAY_CNT_SAT_EN
    // 18 up steps from 0: 1..15, 0 (wrap), 1, 2
    for (int k = 0; k < 18; k++) begin
      b = 4'((k + 1) % 16);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, b, gray_tab[b], (b == 4'd0), 1'b1, "count_up");
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd1, 4'b0001, 1'b0, 1'b0, "down_load");
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'b0000, 1'b0, 1'b1, "down_1to0");
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd15, 4'b1000, 1'b1, 1'b1, "down_0to15");
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd14, 4'b1001, 1'b0, 1'b1, "down_15to14");
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd7, 4'd7, 4'b0100, 1'b0, 1'b0, "prio_load7");
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd9, 4'd0, 4'b0000, 1'b0, 1'b0, "prio_clr_wins");
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd9, 4'd9, 4'b1101, 1'b0, 1'b0, "prio_load_wins");
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd9, 4'b1101, 1'b0, 1'b0, "hold");
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd15, 4'd15, 4'b1000, 1'b0, 1'b0, "load_max");
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'b0000, 1'b0, 1'b0, "load_max_to_0");
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd15, 4'd15, 4'b1000, 1'b0, 1'b0, "cut_load");
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 4'b0000, 1'b1, 1'b1, "cut_wrap");
`else
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd14, 4'd14, 4'b1001, 1'b0, 1'b0, "sat_load14");
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd15, 4'b1000, 1'b0, 1'b1, "sat_up_15");
    for (int k = 0; k < 3; k++)
      drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd15, 4'b1000, 1'b1, 1'b0, "sat_up_blocked");
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'b0000, 1'b0, 1'b0, "sat_load0");
    for (int k = 0; k < 2; k++)
      drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'b0000, 1'b1, 1'b0, "sat_down_blocked");
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd15, 4'd15, 4'b1000, 1'b0, 1'b0, "cut_load");
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd15, 4'b1000, 1'b1, 1'b0, "cut_wrap");
`endif
    async_reset("rst_cut_wrap");
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd11, 4'd11, 4'b1110, 1'b0, 1'b0, "rst_load11");
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd12, 4'b1010, 1'b0, 1'b1, "rst_count12");
    async_reset("rst_at12");

    // Random phase against a behavioural model, starting from a known clear.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 4'd0, 4'd0, 1'b0, 1'b0, "rand_clr");
    mdl_bin = 4'd0;
    for (int k = 0; k < 2000; k++) begin
      c  = ($urandom_range(15) == 0);
      l  = ($urandom_range(7) == 0);
      e  = ($urandom_range(3) != 0);
      u  = $urandom_range(1);
      lv = 4'($urandom_range(15));
      w  = 1'b0;
      stp = 1'b0;
      if (c) mdl_bin = 4'd0;
      else if (l) mdl_bin = lv;
      else if (e) begin
        if (u && mdl_bin == 4'd15) begin
          w = 1'b1;
`ifndef GRAY_CNT_SAT_EN
          mdl_bin = 4'd0; stp = 1'b1;
`endif
        end else if (!u && mdl_bin == 4'd0) begin
          w = 1'b1;
`ifndef GRAY_CNT_SAT_EN
          mdl_bin = 4'd15; stp = 1'b1;
`endif
        end else begin
          mdl_bin = u ? mdl_bin + 4'd1 : mdl_bin - 4'd1;
          stp = 1'b1;
        end
      end
      drive(c, l, e, u, lv, mdl_bin, mdl_bin ^ (mdl_bin >> 1), w, stp, "random");
    end
    @(negedge clk);
    idle_inputs();
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 4'(sb.size()), 4'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
